// File: rtl/candidate_sweep_ctrl_if.sv
// Point/score handshake between the fine-search sequencer and the shared scoring datapath.
// The sequencer issues one test point at a time and receives one score per accepted point.
interface candidate_sweep_ctrl_if #(
  parameter int ANGLE_W = 12,
  parameter int SCORE_W = 16
);
  logic [ANGLE_W-1:0] theta;
  logic [ANGLE_W-1:0] phi;
  logic [ANGLE_W-1:0] alpha;
  logic               pt_valid;
  logic               pt_ready;
  logic [SCORE_W-1:0] score;
  logic               score_valid;

  modport master (
    output theta, phi, alpha, pt_valid,
    input  pt_ready, score, score_valid
  );

  modport slave (
    input  theta, phi, alpha, pt_valid,
    output pt_ready, score, score_valid
  );
endinterface

// File: rtl/candidate_sweep_ctrl.sv
// Fine-search sequencer: expands each sorted candidate into a (theta, phi, alpha) grid,
// feeds points to the scorer one at a time and keeps the best-scoring triple.
module candidate_sweep_ctrl #(
  parameter int N_CAND     = 10,
  parameter int ANGLE_W    = 12,
  parameter int HALF_SPAN  = 1,
  parameter int ALPHA_N    = 4,
  parameter int ALPHA_STEP = 1024,
  parameter int SCORE_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [24*N_CAND-1:0]  candidate_angle_buffer,
  input  logic [3:0]            cand_count,
  input  logic [ANGLE_W-1:0]    delta,
  candidate_sweep_ctrl_if.master sc,
  output logic [ANGLE_W-1:0]    best_theta,
  output logic [ANGLE_W-1:0]    best_phi,
  output logic [ANGLE_W-1:0]    best_alpha,
  output logic [SCORE_W-1:0]    best_score,
  output logic                  best_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int SPAN_N = 2*HALF_SPAN + 1;
  localparam int IDX_W  = (SPAN_N > 1) ? $clog2(SPAN_N) : 1;
  localparam int K_W    = (ALPHA_N > 1) ? $clog2(ALPHA_N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPAN_N - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(ALPHA_N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]         count_r;
  logic [3:0]         c_r;
  logic [ANGLE_W-1:0] delta_r;
  logic [IDX_W-1:0]   t_idx;
  logic [IDX_W-1:0]   p_idx;
  logic [K_W-1:0]     k_r;
  logic [ANGLE_W-1:0] cand_theta;
  logic [ANGLE_W-1:0] cand_phi;
  logic [23:0]        entry;

  logic               k_wrap, p_wrap, t_wrap;
  logic [ANGLE_W-1:0] dt_off, dp_off, dt_mul, dp_mul;

  // Offsets are held as 0..2*HALF_SPAN indices; the signed offset times delta is
  // formed modulo 2^ANGLE_W, so a plain W-bit product gives the wrapped result.
  assign dt_off = ANGLE_W'(t_idx) - ANGLE_W'(HALF_SPAN);
  assign dp_off = ANGLE_W'(p_idx) - ANGLE_W'(HALF_SPAN);
  assign dt_mul = dt_off * delta_r;
  assign dp_mul = dp_off * delta_r;

  assign sc.theta    = cand_theta + dt_mul;
  assign sc.phi      = cand_phi + dp_mul;
  assign sc.alpha    = ANGLE_W'(k_r) * ANGLE_W'(ALPHA_STEP);
  assign sc.pt_valid = (state == S_ISSUE);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign k_wrap = (k_r == K_LAST);
  assign p_wrap = (p_idx == IDX_LAST);
  assign t_wrap = (t_idx == IDX_LAST);

  always_comb begin
    entry = '0;
    for (int unsigned i = 0; i < N_CAND; i++) begin
      if (32'(c_r) == i) entry = candidate_angle_buffer[24*i +: 24];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cand_count == 4'd0) ? S_DONE : S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: if (sc.pt_ready) state_nxt = S_WAIT;
      S_WAIT:  if (sc.score_valid) state_nxt = S_NEXT;
      S_NEXT: begin
        if (k_wrap && p_wrap && t_wrap)
          state_nxt = ((c_r + 4'd1) == count_r) ? S_DONE : S_LOAD;
        else
          state_nxt = S_ISSUE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r    <= '0;
      c_r        <= '0;
      delta_r    <= '0;
      t_idx      <= '0;
      p_idx      <= '0;
      k_r        <= '0;
      cand_theta <= '0;
      cand_phi   <= '0;
      best_theta <= '0;
      best_phi   <= '0;
      best_alpha <= '0;
      best_score <= '0;
      best_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            count_r    <= cand_count;
            delta_r    <= delta;
            c_r        <= '0;
            best_valid <= 1'b0;
            best_score <= '0;
          end
        end
        S_LOAD: begin
          cand_theta <= ANGLE_W'(entry[23:12]);
          cand_phi   <= ANGLE_W'(entry[11:0]);
          t_idx      <= '0;
          p_idx      <= '0;
          k_r        <= '0;
        end
        S_WAIT: begin
          if (sc.score_valid && (!best_valid || (sc.score > best_score))) begin
            best_theta <= sc.theta;
            best_phi   <= sc.phi;
            best_alpha <= sc.alpha;
            best_score <= sc.score;
            best_valid <= 1'b1;
          end
        end
        S_NEXT: begin
          if (!k_wrap) begin
            k_r <= k_r + 1'b1;
          end else begin
            k_r <= '0;
            if (!p_wrap) begin
              p_idx <= p_idx + 1'b1;
            end else begin
              p_idx <= '0;
              if (!t_wrap) begin
                t_idx <= t_idx + 1'b1;
              end else begin
                t_idx <= '0;
                c_r   <= c_r + 4'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/candidate_sweep_ctrl.md
Name: candidate_sweep_ctrl

Overview:
- Sequences the fine-search stage of the attitude matcher.
- Walks the sorted candidate buffer and expands each candidate (theta, phi) into a local grid of (theta, phi, alpha) test points.
- Issues the points one at a time to the shared scoring datapath and collects one score per point.
- Reports the best-scoring triple once the sweep completes.
- Sits between the sorter (sorted_rdy / candidate_angle_buffer) and the scoring unit.

Parameters:
- N_CAND, 10, candidate buffer depth (entries of 24 bits).
- ANGLE_W, 12, angle width; all angle arithmetic is modulo 2^ANGLE_W.
- HALF_SPAN, 1, grid half-width; offsets -HALF_SPAN..+HALF_SPAN in theta and phi.
- ALPHA_N, 4, number of alpha steps per (theta, phi) point.
- ALPHA_STEP, 1024, alpha increment; alpha = k*ALPHA_STEP, k = 0..ALPHA_N-1, wraps mod 2^ANGLE_W.
- SCORE_W, 16, score width (unsigned).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  level/pulse; sampled in IDLE only.
- candidate_angle_buffer  in  24*N_CAND  entry i = bits [24*i+23 -: 24] = {theta[23:12], phi[11:0]}.
- cand_count  in  4  number of valid entries (0..N_CAND); latched at start.
- delta  in  ANGLE_W  theta/phi grid step; latched at start.
- theta, phi, alpha  out  ANGLE_W each  current test point.
- pt_valid  out  1  test point valid.
- pt_ready  in  1  scorer accepts point.
- score  in  SCORE_W  returned score.
- score_valid  in  1  score strobe.
- best_theta, best_phi, best_alpha  out  ANGLE_W each  winning point.
- best_score  out  SCORE_W  winning score.
- best_valid  out  1  at least one point was scored.
- busy  out  1  high from LOAD until DONE, inclusive.
- done  out  1  one-cycle pulse at sweep end.

Behaviour:
- Reset (async, rst=0): FSM to IDLE; all outputs 0; counters cleared.
- Reset mid-sweep aborts with no done pulse.
- States: IDLE, LOAD, ISSUE, WAIT, NEXT, DONE.
- IDLE:
  - start=1 latches cand_count and delta; goes to LOAD.
  - Clears best_valid and best_score.
  - Leaves best_theta, best_phi and best_alpha unchanged until the first score is taken.
- IDLE with cand_count=0 at start: goes straight to DONE; best_valid stays 0.
- LOAD: reads entry c (c starts at 0); sets offsets dt = dp = -HALF_SPAN and k = 0; goes to ISSUE.
- First pt_valid appears 2 cycles after start is sampled.
- ISSUE:
  - pt_valid=1 with theta = cand_theta + dt*delta, phi = cand_phi + dp*delta, alpha = k*ALPHA_STEP, all truncated to ANGLE_W (natural wrap).
  - theta, phi and alpha are held stable while pt_valid=1 and pt_ready=0.
  - On pt_valid & pt_ready, pt_valid drops the next cycle and the FSM goes to WAIT.
- WAIT: waits for score_valid; exactly one point is outstanding.
- score_valid in any other state is ignored.
- Score update in WAIT on score_valid:
  - If best_valid=0 or score > best_score (strictly greater; ties keep the earlier point), the point is captured into the best_* outputs and best_valid is set.
  - Then goes to NEXT.
- NEXT, counter order from innermost: k, then dp, then dt, then c.
  - k increments; wraps at ALPHA_N and carries into dp.
  - dp increments; wraps at +HALF_SPAN and carries into dt.
  - dt wraps at +HALF_SPAN and carries into c.
  - c increments; c = cand_count ends the sweep and goes to DONE.
  - A carry into c goes to LOAD; otherwise back to ISSUE.
- Points per candidate = (2*HALF_SPAN+1)^2 * ALPHA_N (36 at defaults).
- DONE: done=1 for one cycle, busy=0 the next cycle, back to IDLE.
- best_* values hold until the next accepted start.
- start while busy is ignored.
- A new sorted buffer may change during a sweep; only entry c is read, at LOAD.

Test Plan:
- Basic order and count:
  - Stimulus: cand_count=1, entry0 = {100,200}, delta=5, pt_ready=1, score returned 1 cycle later.
  - Required: first point (95,195,0), second (95,195,1024), fifth (95,200,0), last (105,205,3072).
  - Required: exactly 36 handshakes, then a done pulse.
- Wrap:
  - Stimulus: entry0 = {2,4094}, delta=5.
  - Required: first point (4093,4089,0); point with dt=0, dp=+1 is (2,3,...).
- Best tracking and ties:
  - Stimulus: scores all 10 except 50 on point index 7 and 50 again on point 20.
  - Required: best = point 7, best_score=50, best_valid=1.
- Backpressure:
  - Stimulus: pt_ready held low for 5 cycles on the first point.
  - Required: theta, phi and alpha stable and pt_valid high throughout; single handshake; no skipped point.
- Multi-candidate:
  - Stimulus: cand_count=10, entries i*21 as {theta,phi}, constant scores.
  - Required: 360 points; best equals the first point of candidate 0; done once.
- Reset and empty:
  - Stimulus: rst=0 mid-WAIT.
  - Required: all outputs 0 immediately, no done.
  - Stimulus: start with cand_count=0.
  - Required: done within 2 cycles, best_valid=0, pt_valid never asserted.
